// File: rtl/floo_pkg.sv
// Shared FlooNoC definitions: AXI response codes, their merge rule and the join FSM states.
package floo_pkg;

  localparam int unsigned RespWidth = 2;

  localparam logic [RespWidth-1:0] RespOkay   = 2'd0;
  localparam logic [RespWidth-1:0] RespSlvErr = 2'd2;
  localparam logic [RespWidth-1:0] RespDecErr = 2'd3;

  typedef enum logic [1:0] {StIdle, StCollect, StSend} join_state_e;

  // The most severe code wins; AXI encodes severity in increasing order.
  function automatic logic [RespWidth-1:0] floo_resp_merge(input logic [RespWidth-1:0] a,
                                                           input logic [RespWidth-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Common-cells style synchronous FIFO with flush, fill level and wrap-around pointers.
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  logic [ADDR_DEPTH-1:0] wptr_q, rptr_q;
  logic [ADDR_DEPTH:0]   cnt_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  do_push, do_pop;

  assign full_o  = (cnt_q == (ADDR_DEPTH + 1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q[ADDR_DEPTH-1:0];
  assign data_o  = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= (wptr_q == ADDR_DEPTH'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= (rptr_q == ADDR_DEPTH'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!do_push && do_pop) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/lzc.sv
// Common-cells style leading/trailing zero counter (MODE 0: trailing, MODE 1: leading).
module lzc #(
  parameter int unsigned WIDTH     = 2,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  // The last hit in scan order wins, so scan away from the end being counted.
  always_comb begin
    cnt_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (MODE) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
      end else begin
        if (in_i[WIDTH-1-i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
      end
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/floo_mcast_rsp_join.sv
// Joins the responses of a forked (multi/unicast) request back into one upstream response,
// keeping request order via a FIFO of the output masks used on the request path.
module floo_mcast_rsp_join
  import floo_pkg::*;
#(
  parameter int unsigned NumRoutes      = 5,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned ErrWidth       = 2,
  parameter type         flit_t         = logic,
  localparam int unsigned OutW          = idx_width(MaxOutstanding + 1),
  localparam int unsigned AddrW         = idx_width(MaxOutstanding),
  localparam int unsigned IdxW          = idx_width(NumRoutes)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               req_valid_i,
  output logic                               req_ready_o,
  input  logic [NumRoutes-1:0]               req_mask_i,
  input  logic [NumRoutes-1:0]               rsp_valid_i,
  output logic [NumRoutes-1:0]               rsp_ready_o,
  input  flit_t [NumRoutes-1:0]              rsp_data_i,
  input  logic [NumRoutes-1:0][ErrWidth-1:0] rsp_err_i,
  output logic                               rsp_valid_o,
  input  logic                               rsp_ready_i,
  output flit_t                              rsp_data_o,
  output logic [ErrWidth-1:0]                rsp_err_o,
  output logic [OutW-1:0]                    outstanding_o
);

  join_state_e          state_q;
  logic [NumRoutes-1:0] head_mask, recv_q, accept;
  logic [ErrWidth-1:0]  err_q, err_d;
  flit_t                data_q;
  logic                 fifo_full, fifo_empty, push, pop, mask_empty;
  logic [AddrW-1:0]     fifo_usage;
  logic [IdxW-1:0]      lsb_idx;

  fifo_v3 #(
    .DATA_WIDTH (NumRoutes),
    .DEPTH      (MaxOutstanding)
  ) i_mask_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage),
    .data_i  (req_mask_i),
    .push_i  (push),
    .data_o  (head_mask),
    .pop_i   (pop)
  );

  lzc #(
    .WIDTH (NumRoutes),
    .MODE  (1'b0)
  ) i_lsb (
    .in_i    (head_mask),
    .cnt_o   (lsb_idx),
    .empty_o (mask_empty)
  );

  assign req_ready_o   = ~fifo_full;
  assign push          = req_valid_i & req_ready_o;
  assign pop           = (state_q == StSend) & rsp_ready_i;
  // usage_o wraps to zero when full, so the full flag supplies the top count.
  assign outstanding_o = fifo_full ? OutW'(MaxOutstanding) : OutW'(fifo_usage);
  assign rsp_ready_o   = (state_q == StCollect) ? (head_mask & ~recv_q) : '0;
  assign accept        = rsp_valid_i & rsp_ready_o;
  assign rsp_valid_o   = (state_q == StSend);
  assign rsp_data_o    = data_q;
  assign rsp_err_o     = err_q;

  always_comb begin
    err_d = err_q;
    for (int unsigned i = 0; i < NumRoutes; i++) begin
      if (accept[i]) err_d = floo_resp_merge(err_d, rsp_err_i[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      recv_q  <= '0;
      err_q   <= RespOkay;
      data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) state_q <= StCollect;
        end
        StCollect: begin
          recv_q <= recv_q | accept;
          err_q  <= err_d;
          if (!mask_empty && accept[lsb_idx]) data_q <= rsp_data_i[lsb_idx];
          if ((recv_q | accept) == head_mask) state_q <= StSend;
        end
        StSend: begin
          if (rsp_ready_i) begin
            recv_q  <= '0;
            err_q   <= RespOkay;
            state_q <= (outstanding_o > OutW'(1) || push) ? StCollect : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifndef SYNTHESIS
  logic [NumRoutes-1:0][10:0] stray_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stray_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NumRoutes; i++) begin
        if (rsp_valid_i[i] && !(head_mask[i] && !fifo_empty)) begin
          stray_cnt_q[i] <= stray_cnt_q[i] + 1'b1;
        end else begin
          stray_cnt_q[i] <= '0;
        end
      end
    end
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) push |-> !fifo_full);
  a_mask_nonzero: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   push |-> (req_mask_i != '0));

  for (genvar g = 0; g < NumRoutes; g++) begin : gen_rsp_asserts
    a_valid_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     rsp_valid_i[g] && !rsp_ready_o[g] |=> rsp_valid_i[g]);
    a_no_stray: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 stray_cnt_q[g] < 11'd1024);
  end
`endif

endmodule

// File: tb/tb_floo_mcast_rsp_join.sv
// Bench for floo_mcast_rsp_join: table vectors, directed corner sequences, random scoreboard.
module tb_floo_mcast_rsp_join;
  import floo_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready_o;
  logic [4:0]       req_mask = '0;
  logic [4:0]       rsp_valid = '0;
  logic [4:0]       rsp_ready_o;
  logic [4:0][7:0]  rsp_data = '0;
  logic [4:0][1:0]  rsp_err = '0;
  logic             rsp_valid_o;
  logic             rsp_ready_i = 1'b0;
  logic [7:0]       rsp_data_o;
  logic [1:0]       rsp_err_o;
  logic [2:0]       outstanding_o;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  floo_mcast_rsp_join #(
    .NumRoutes      (5),
    .MaxOutstanding (4),
    .ErrWidth       (2),
    .flit_t         (logic [7:0])
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready_o),
    .req_mask_i    (req_mask),
    .rsp_valid_i   (rsp_valid),
    .rsp_ready_o   (rsp_ready_o),
    .rsp_data_i    (rsp_data),
    .rsp_err_i     (rsp_err),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_data_o    (rsp_data_o),
    .rsp_err_o     (rsp_err_o),
    .outstanding_o (outstanding_o)
  );

  typedef struct packed {
    logic [4:0]      mask;
    logic [4:0][7:0] data;
    logic [4:0][1:0] err;
    logic [1:0]      exp_err;
    logic [7:0]      exp_data;
  } vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] err;
  } rsp_t;

  vec_t vecs [5];
  rsp_t port_q [5][$];
  rsp_t exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One clock; a port's valid drops once the DUT has taken its response.
  task automatic cyc();
    logic [4:0] acc;
    acc = rsp_valid & rsp_ready_o;
    @(posedge clk);
    #1;
    rsp_valid = rsp_valid & ~acc;
  endtask

  task automatic push_mask(input logic [4:0] m);
    req_valid = 1'b1;
    req_mask  = m;
    cyc();
    req_valid = 1'b0;
  endtask

  // Returns cycles between the last accept and rsp_valid_o (-1 on timeout).
  task automatic run_until_valid(output int lat);
    int last_acc;
    last_acc = -1;
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      if ((rsp_valid & rsp_ready_o) != '0) last_acc = c;
      cyc();
      if (rsp_valid_o) begin
        lat = c - last_acc;
        break;
      end
    end
  endtask

  task automatic pop_one();
    rsp_ready_i = 1'b1;
    cyc();
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int got;
    logic [7:0] bp_data [4];
    logic [1:0] bp_err [4];

    vecs[0] = '{5'b00100, {8'h00, 8'h00, 8'hA1, 8'h00, 8'h00},
                {2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 2'd0, 8'hA1};
    vecs[1] = '{5'b01110, {8'h00, 8'h33, 8'h22, 8'h11, 8'h00},
                {2'd0, 2'd2, 2'd0, 2'd3, 2'd0}, 2'd3, 8'h11};
    vecs[2] = '{5'b11111, {8'h44, 8'h43, 8'h42, 8'h41, 8'h40},
                {2'd0, 2'd0, 2'd0, 2'd2, 2'd0}, 2'd2, 8'h40};
    vecs[3] = '{5'b10000, {8'h5A, 8'h00, 8'h00, 8'h00, 8'h00},
                {2'd2, 2'd0, 2'd0, 2'd0, 2'd0}, 2'd2, 8'h5A};
    vecs[4] = '{5'b11000, {8'h77, 8'h66, 8'h00, 8'h00, 8'h00},
                {2'd0, 2'd3, 2'd0, 2'd0, 2'd0}, 2'd3, 8'h66};

    // Reset values
    #3;
    check("rst_valid", rsp_valid_o, 0);
    check("rst_req_ready", req_ready_o, 1);
    check("rst_outstanding", outstanding_o, 0);
    check("rst_rsp_ready", rsp_ready_o, 0);
    check("rst_err_data", {rsp_err_o, rsp_data_o}, 0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors: all contributors valid at once
    for (int v = 0; v < 5; v++) begin
      push_mask(vecs[v].mask);
      rsp_valid = vecs[v].mask;
      rsp_data  = vecs[v].data;
      rsp_err   = vecs[v].err;
      run_until_valid(lat);
      check($sformatf("vec%0d_latency", v), lat, 0);
      check($sformatf("vec%0d_err", v), rsp_err_o, vecs[v].exp_err);
      check($sformatf("vec%0d_data", v), rsp_data_o, vecs[v].exp_data);
      pop_one();
      check($sformatf("vec%0d_valid_after_pop", v), rsp_valid_o, 0);
    end

    // Multicast with skewed arrivals on ports 4, 0, 1
    push_mask(5'b10011);
    cyc();
    cyc();
    rsp_data = {8'hD4, 8'h00, 8'h00, 8'h00, 8'h00};
    rsp_err  = '0;
    rsp_valid = 5'b10000;
    check("skew_ready_all", rsp_ready_o, 5'b10011);
    cyc();
    check("skew_ready_after_p4", rsp_ready_o, 5'b00011);
    cyc();
    cyc();
    cyc();
    rsp_data[0] = 8'h5C;
    rsp_valid = 5'b00001;
    cyc();
    check("skew_ready_after_p0", rsp_ready_o, 5'b00010);
    check("skew_no_early_valid", rsp_valid_o, 0);
    cyc();
    rsp_data[1] = 8'h77;
    rsp_err[1]  = 2'd2;
    rsp_valid = 5'b00010;
    cyc();
    check("skew_valid", rsp_valid_o, 1);
    check("skew_err", rsp_err_o, RespSlvErr);
    check("skew_data", rsp_data_o, 8'h5C);
    pop_one();

    // Fill the FIFO and back-pressure the merged response
    bp_data = '{8'h10, 8'h21, 8'h32, 8'h43};
    bp_err  = '{2'd0, 2'd2, 2'd3, 2'd0};
    rsp_data = {8'h00, 8'h43, 8'h32, 8'h21, 8'h10};
    rsp_err  = {2'd0, 2'd0, 2'd3, 2'd2, 2'd0};
    rsp_valid = 5'b01111;
    for (int k = 0; k < 4; k++) push_mask(5'(1 << k));
    check("bp_req_ready_full", req_ready_o, 0);
    check("bp_outstanding_full", outstanding_o, 4);
    got = 0;
    for (int c = 0; c < 20 && !rsp_valid_o; c++) cyc();
    for (int c = 0; c < 5; c++) begin
      check("bp_hold_valid", rsp_valid_o, 1);
      check("bp_hold_ready", rsp_ready_o, 0);
      check("bp_hold_data", {rsp_err_o, rsp_data_o, outstanding_o}, {2'd0, 8'h10, 3'd4});
      cyc();
    end
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (rsp_valid_o) begin
        check($sformatf("bp_order%0d_data", got), rsp_data_o, bp_data[got]);
        check($sformatf("bp_order%0d_err", got), rsp_err_o, bp_err[got]);
        got++;
      end
      cyc();
    end
    rsp_ready_i = 1'b0;
    check("bp_count", got, 4);
    check("bp_drained", {rsp_valid_o, outstanding_o}, 0);

    // Stray response on a port not in the head mask
    push_mask(5'b00001);
    push_mask(5'b01000);
    rsp_data = {8'h00, 8'h33, 8'h00, 8'h00, 8'h0A};
    rsp_err  = {2'd0, 2'd2, 2'd0, 2'd0, 2'd0};
    rsp_valid = 5'b01000;
    cyc();
    check("stray_blocked0", rsp_ready_o, 5'b00001);
    cyc();
    cyc();
    check("stray_blocked1", rsp_ready_o[3], 0);
    rsp_valid[0] = 1'b1;
    cyc();
    check("stray_first_valid", {rsp_valid_o, rsp_data_o}, {1'b1, 8'h0A});
    check("stray_blocked_send", rsp_ready_o[3], 0);
    pop_one();
    check("stray_now_ready", rsp_ready_o[3], 1);
    cyc();
    check("stray_second", {rsp_valid_o, rsp_err_o, rsp_data_o}, {1'b1, 2'd2, 8'h33});
    pop_one();

    // Asynchronous reset in the middle of a collection
    push_mask(5'b00011);
    cyc();
    rsp_data = {8'h00, 8'h00, 8'h00, 8'h9E, 8'hC3};
    rsp_err  = {2'd0, 2'd0, 2'd0, 2'd0, 2'd3};
    rsp_valid = 5'b00001;
    cyc();
    check("mid_partial_ready", rsp_ready_o, 5'b00010);
    check("mid_partial_err", rsp_err_o, RespDecErr);
    #3;
    rst_n = 1'b0;
    rsp_valid = '0;
    #1;
    check("arst_outputs", {rsp_valid_o, rsp_ready_o, rsp_err_o, rsp_data_o}, 0);
    check("arst_req_ready", req_ready_o, 1);
    check("arst_outstanding", outstanding_o, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_mask(5'b00010);
    rsp_err[1] = 2'd0;
    rsp_valid = 5'b00010;
    run_until_valid(lat);
    check("post_rst_latency", lat, 0);
    check("post_rst_rsp", {rsp_err_o, rsp_data_o}, {2'd0, 8'h9E});
    pop_one();

    // Random traffic against a transaction-level scoreboard
    rsp_valid = '0;
    for (int c = 0; c < 3000 || (c < 4000 && exp_q.size() != 0); c++) begin
      logic [4:0] acc;
      logic       pushed, popped;
      if (!req_valid) begin
        req_valid = (c < 3000) && ($urandom_range(0, 2) == 0);
        req_mask  = 5'($urandom_range(1, 31));
      end
      for (int i = 0; i < 5; i++) begin
        if (!rsp_valid[i] && port_q[i].size() != 0 && $urandom_range(0, 1) == 1)
          rsp_valid[i] = 1'b1;
        if (rsp_valid[i]) begin
          rsp_data[i] = port_q[i][0].data;
          rsp_err[i]  = port_q[i][0].err;
        end
      end
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      check("rnd_outstanding", outstanding_o, exp_q.size());
      pushed = req_valid & req_ready_o;
      acc    = rsp_valid & rsp_ready_o;
      popped = rsp_valid_o & rsp_ready_i;
      if (popped) begin
        if (exp_q.size() == 0) check("rnd_unexpected_rsp", 1, 0);
        else check("rnd_rsp", {rsp_err_o, rsp_data_o}, {exp_q[0].err, exp_q[0].data});
      end
      @(posedge clk);
      #1;
      if (popped && exp_q.size() != 0) void'(exp_q.pop_front());
      for (int i = 0; i < 5; i++) begin
        if (acc[i]) begin
          void'(port_q[i].pop_front());
          rsp_valid[i] = 1'b0;
        end
      end
      if (pushed) begin
        rsp_t e;
        bit   first;
        e = '0;
        first = 1'b1;
        for (int i = 0; i < 5; i++) begin
          if (req_mask[i]) begin
            rsp_t r;
            r.data = 8'($urandom);
            r.err  = 2'($urandom);
            port_q[i].push_back(r);
            if (r.err > e.err) e.err = r.err;
            if (first) e.data = r.data;
            first = 1'b0;
          end
        end
        exp_q.push_back(e);
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    rsp_ready_i = 1'b0;
    check("rnd_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/floo_mcast_rsp_join.md
Name: floo_mcast_rsp_join

Overview:
- Sits on the response path of a router input port that forwarded a multicast request to several outputs.
- Records, per outstanding multicast, the output mask used on the request path.
- Collects exactly one response from every output in that mask, then merges them into a single response for the upstream requester.
- Unicast (single-bit masks) uses the same path, so request order is preserved.

Parameters:
- NumRoutes, 5, number of router output ports that can return responses.
- MaxOutstanding, 4, depth of the expected-mask FIFO (outstanding requests).
- ErrWidth, 2, width of the error/resp code (AXI encoding: 0 OKAY, 2 SLVERR, 3 DECERR).
- flit_t, logic, response payload type passed through unmodified.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset: asynchronous, active-low.
- req_valid_i  in  1  a request was forked; push its mask.
- req_ready_o  out  1  mask FIFO not full.
- req_mask_i  in  NumRoutes  outputs the request was sent to.
- rsp_valid_i  in  NumRoutes  per-port response valid.
- rsp_ready_o  out  NumRoutes  per-port response accept.
- rsp_data_i  in  NumRoutes x flit_t  per-port response payload.
- rsp_err_i  in  NumRoutes x ErrWidth  per-port resp code.
- rsp_valid_o  out  1  merged response valid.
- rsp_ready_i  in  1  upstream accepts merged response.
- rsp_data_o  out  flit_t  merged payload.
- rsp_err_o  out  ErrWidth  merged resp code.
- outstanding_o  out  idx_width(MaxOutstanding+1)  FIFO fill level.

Behaviour:
- Handshake is valid/ready: transfer when both are high; valid must stay stable until ready.
- Reset values: all outputs 0, except req_ready_o=1. FIFO empty, recv_q=0, err_q=0, state IDLE.
- Mask FIFO:
  - Push on req_valid_i & req_ready_o.
  - req_ready_o = !full; it depends on full only, so a push and a pop in the same cycle while full is not possible.
  - Push and pop in the same cycle when not full is allowed; the level is unchanged.
  - Pointers wrap modulo MaxOutstanding.
- Per-port accept: rsp_ready_o[i] = (state==COLLECT) & head_mask[i] & ~recv_q[i].
  - Ports outside the head mask, or already received, see ready=0.
  - Responses from multiple ports in the same cycle are all accepted.
- On accept at port i:
  - recv_q[i] <= 1.
  - err_q <= max(err_q, rsp_err_i[i]).
  - data_q <= rsp_data_i[i] if i is the lowest set bit of head_mask. Only that port's payload is kept.
- State machine:
  - IDLE -> COLLECT when the FIFO is non-empty. This is one cycle after the first push.
  - COLLECT -> SEND in the cycle where recv_q | accepted == head_mask.
  - SEND: rsp_valid_o=1, rsp_data_o=data_q, rsp_err_o=err_q, all rsp_ready_o=0.
  - SEND, on rsp_ready_i: pop the FIFO and clear recv_q and err_q. Next state is COLLECT if the FIFO is still non-empty after the pop (push in the same cycle counts), else IDLE.
- Latency: rsp_valid_o rises the cycle after the last required response is accepted (registered output). Minimum back-to-back throughput is one merged response per 2 cycles.
- Unicast mask behaves identically with a single contributor. rsp_err_o equals that port's code.
- Empty mask (req_mask_i==0) pushed is illegal: assertion fires. The RTL is not required to handle it.
- Asynchronous reset mid-operation discards the FIFO contents and all partial collection. Outputs return to their reset values immediately.
- Assertions:
  - No rsp_valid_i stays high on a port outside the head mask for more than 1024 cycles (debug aid only, disabled under synthesis).
  - The FIFO is never pushed when full.
  - Response valid stability is asserted on every port.

Decomposition:
- Shared package floo_pkg gains:
  - the resp-code constants RespOkay, RespSlvErr, RespDecErr;
  - a function floo_resp_merge(a,b) returning the max code.
- The mask FIFO reuses the common-cells fifo_v3 (Depth=MaxOutstanding, DATA_WIDTH=NumRoutes), with no new sub-module.
- Lowest-set-bit selection uses lzc (trailing-zero mode).
- The collect/send FSM stays in the top module.

Test Plan:
- Unicast: push mask 5'b00100; port 2 returns err=0, data=0xA1. The merged response has err=0, data=0xA1 and rsp_valid_o asserts 1 cycle after the accept.
- Multicast skew: mask 5'b10011; responses arrive on ports 4, 0, 1 in cycles 3, 7, 9 with err 0,0,2.
  - rsp_valid_o asserts at cycle 10 with err=2, data=port-0 payload.
  - Each port's ready drops after its accept.
- Simultaneous: mask 5'b01110 with all three ports valid in the same cycle and err 3,0,2. All are accepted at once; merged err=3.
- Ordering/back-pressure: push 4 masks (FIFO full) and check req_ready_o=0. Hold rsp_ready_i=0 for 5 cycles in SEND.
  - rsp_ready_o stays 0, outputs stay stable and outstanding_o=4.
  - Releasing rsp_ready_i gives 4 merged responses in push order.
- Stray response: port 3 valid while the head mask is 5'b00001. rsp_ready_o[3]=0 until a later mask containing port 3 reaches the head, then it is accepted.
- Reset mid-collect: mask 5'b00011 with port 0 received, then pulse rst_ni low.
  - Outputs are 0 and req_ready_o=1 asynchronously, with outstanding_o=0.
  - A fresh mask 5'b00010 completes on a single port-1 response.
